hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit covering operand forwarding, load-use stalls,
// branch flushes and a data-memory wait FSM with a timeout error state.
// Optional macro HAZARD_PERF_EN adds saturating 16-bit performance counters
// (LwStallCnt, FlushCnt, MemWaitCnt).
// Stall/Flush/Forward outputs are combinational; MemErr and the counters are registered.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
`ifdef HAZARD_PERF_EN
    output logic [15:0] LwStallCnt,
    output logic [15:0] FlushCnt,
    output logic [15:0] MemWaitCnt,
`endif
    output logic       MemErr
);

    localparam int unsigned WAIT_W     = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(63);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t            state;
    logic [WAIT_W-1:0] waitCnt;
    logic              lwStall;
    logic              memStart;
    logic              holdAll;

    // Forwarding select: the newer result in Memory wins over Writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    // Stall/flush decode; a memory stall freezes the whole pipe and masks branch/load-use.
    always_comb begin
        lwStall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        memStart = (state == RUN) && MemReqM && !MemReadyM;
        holdAll  = (state != RUN) || memStart;
        StallF   = lwStall;
        StallD   = lwStall;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = PCSrcE;
        FlushE   = lwStall | PCSrcE;
        FlushW   = 1'b0;
        if (holdAll) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    // Memory wait FSM with timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= '0;
            MemErr  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memStart) begin
                        state   <= MEM_WAIT;
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state <= RUN;
                    end else if (waitCnt == WAIT_LIMIT) begin
                        state  <= ERROR;
                        MemErr <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    MemErr <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters for load-use stalls, branch flushes and memory wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            LwStallCnt <= '0;
            FlushCnt   <= '0;
            MemWaitCnt <= '0;
        end else begin
            if ((state == RUN) && lwStall && (LwStallCnt != 16'hFFFF))
                LwStallCnt <= LwStallCnt + 16'd1;
            if ((state == RUN) && PCSrcE && (FlushCnt != 16'hFFFF))
                FlushCnt <= FlushCnt + 16'd1;
            if ((state == MEM_WAIT) && (MemWaitCnt != 16'hFFFF))
                MemWaitCnt <= MemWaitCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: behavioural reference model compared every cycle,
// plus directed literal checks for forwarding, load-use, branch, memory wait and timeout.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [15:0] LwStallCnt, FlushCnt, MemWaitCnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
        .LwStallCnt(LwStallCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt),
`endif
        .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // waiting: pipeline frozen on memory; waited: MEM_WAIT cycles spent so far;
    // failed: memory never answered within 64 wait cycles.
    bit modelValid = 0;
    bit waiting = 0;
    bit failed  = 0;
    int waited  = 0;
    int mLw = 0, mFl = 0, mMw = 0;

    function automatic logic [1:0] fwdSel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit loadUse();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            modelValid = 1; waiting = 0; failed = 0; waited = 0;
            mLw = 0; mFl = 0; mMw = 0;
        end else if (modelValid) begin
            if (failed) begin
                // stuck until reset
            end else if (waiting) begin
                mMw = sat(mMw + 1);
                waited++;
                if (MemReadyM) waiting = 0;
                else if (waited == 64) begin waiting = 0; failed = 1; end
            end else begin
                if (loadUse()) mLw = sat(mLw + 1);
                if (PCSrcE)    mFl = sat(mFl + 1);
                if (MemReqM && !MemReadyM) begin waiting = 1; waited = 0; end
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (modelValid) begin
            bit frozen, lw;
            frozen = failed || waiting || (MemReqM && !MemReadyM);
            lw = loadUse();
            check("ForwardAE", 16'(ForwardAE), 16'(fwdSel(Rs1E)));
            check("ForwardBE", 16'(ForwardBE), 16'(fwdSel(Rs2E)));
            check("StallF", 16'(StallF), 16'(frozen | lw));
            check("StallD", 16'(StallD), 16'(frozen | lw));
            check("StallE", 16'(StallE), 16'(frozen));
            check("StallM", 16'(StallM), 16'(frozen));
            check("FlushW", 16'(FlushW), 16'(frozen));
            check("FlushD", 16'(FlushD), 16'(!frozen & PCSrcE));
            check("FlushE", 16'(FlushE), 16'(!frozen & (PCSrcE | lw)));
            check("MemErr", 16'(MemErr), 16'(failed));
`ifdef HAZARD_PERF_EN
            check("LwStallCnt", LwStallCnt, 16'(mLw));
            check("FlushCnt", FlushCnt, 16'(mFl));
            check("MemWaitCnt", MemWaitCnt, 16'(mMw));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic clearInputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1; tick(2); rst = 0;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        tick(2);
        rst = 0;
        @(negedge clk);
        check("lit_reset_MemErr", 16'(MemErr), 16'd0);
        check("lit_reset_StallF", 16'(StallF), 16'd0);
        tick(1);

        // Forwarding priority
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        @(negedge clk); check("lit_fwd_M", 16'(ForwardAE), 16'h2);
        RdM = 0;
        @(negedge clk); check("lit_fwd_W", 16'(ForwardAE), 16'h1);
        RegWriteW = 0;
        @(negedge clk); check("lit_fwd_RF", 16'(ForwardAE), 16'h0);
        tick(1); clearInputs();

        // Load-use stall
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        @(negedge clk);
        check("lit_lw_StallF", 16'(StallF), 16'd1);
        check("lit_lw_FlushE", 16'(FlushE), 16'd1);
        check("lit_lw_FlushD", 16'(FlushD), 16'd0);
        tick(1);
        RdE = 0;
        @(negedge clk); check("lit_lw_rd0", 16'(StallD), 16'd0);
        tick(1); clearInputs();

        // Branch plus load-use
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 1;
        @(negedge clk);
        check("lit_br_lw_FlushD", 16'(FlushD), 16'd1);
        check("lit_br_lw_FlushE", 16'(FlushE), 16'd1);
        check("lit_br_lw_StallD", 16'(StallD), 16'd1);
        tick(1); clearInputs();

        // Memory wait: ready low three cycles, then high
        doReset();
        begin
            int stallCycles = 0;
            MemReqM = 1; MemReadyM = 0;
            for (int i = 0; i < 6; i++) begin
                if (i == 3) MemReadyM = 1;
                if (i == 4) MemReqM = 0;
                @(negedge clk);
                if (StallM && FlushW) stallCycles++;
                tick(1);
            end
            check("lit_memwait_cycles", 16'(stallCycles), 16'd4);
        end
`ifdef HAZARD_PERF_EN
        check("lit_memwait_cnt", MemWaitCnt, 16'd3);
`endif

        // Ready exactly at the last allowed wait cycle returns to RUN
        doReset();
        MemReqM = 1; MemReadyM = 0;
        tick(64);
        MemReadyM = 1; MemReqM = 0;
        tick(1);
        @(negedge clk);
        check("lit_edge_MemErr", 16'(MemErr), 16'd0);
        check("lit_edge_StallE", 16'(StallE), 16'd0);
        tick(1);

        // Timeout into ERROR
        doReset();
        MemReqM = 1; MemReadyM = 0;
        tick(64);
        @(negedge clk); check("lit_to_before", 16'(MemErr), 16'd0);
        tick(1);
        @(negedge clk); check("lit_to_set", 16'(MemErr), 16'd1);
        tick(5);
        MemReadyM = 1; MemReqM = 0;
        tick(1);
        @(negedge clk);
        check("lit_to_sticky", 16'(MemErr), 16'd1);
        check("lit_to_stall", 16'(StallF), 16'd1);
        tick(1);
        rst = 1; tick(1); rst = 0;
        @(negedge clk);
        check("lit_to_rst_MemErr", 16'(MemErr), 16'd0);
        check("lit_to_rst_StallE", 16'(StallE), 16'd0);
        tick(1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MemReqM   = ($urandom_range(0, 4) == 0);
            MemReadyM = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 0;

`ifdef HAZARD_PERF_EN
        // Counter saturation under a permanent load-use hazard
        clearInputs();
        doReset();
        ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
        tick(70000);
        @(negedge clk);
        check("lit_sat_LwStallCnt", LwStallCnt, 16'hFFFF);
        tick(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
